tape_saver: RTL and testbench

TAPE_SAVER -- requirements
Module: tape_saver

---
 rtl/tape_saver.sv | 168 ++++++++++++++++
 tb/tb_tape_saver.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tape_saver.sv
// ZX8x tape capture: counts mic pulses per bit, assembles MSB-first bytes,
// drops the filename and stores the program bytes for the host to read back.
module tape_saver #(
    parameter int GAP_TICKS = 4550,
    parameter int END_TICKS = 3250000,
    parameter bit SKIP_NAME = 1'b1,
    parameter int ADDR_W    = 14
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce,
    input  logic              enable,
    input  logic              mic,
    input  logic              ack,
    output logic              active,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   length,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    localparam int TMR_W = 22;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [TMR_W-1:0] GAP_LIM = TMR_W'(GAP_TICKS);
    localparam logic [TMR_W-1:0] END_LIM = TMR_W'(END_TICKS);
    localparam logic [ADDR_W:0]  LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, BIT, GAP, DONE} state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync2_q, prev_q;
    logic [3:0]        pulse_q, pulse_d;
    logic [TMR_W-1:0]  timer_q, timer_d, timer_inc;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [7:0]        byte_q, byte_d, shifted;
    logic              name_q, name_d;
    logic [ADDR_W:0]   length_q, length_d;
    logic              ovf_q, ovf_d;
    logic              rise, bit_val;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic [7:0]        mem [DEPTH];

    // prev_q only advances on ce so an edge is seen exactly once per ce tick
    assign rise      = ce && sync2_q && !prev_q;
    assign bit_val   = (pulse_q >= 4'd7);
    assign shifted   = {byte_q[6:0], bit_val};
    assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= IDLE;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            pulse_q  <= '0;
            timer_q  <= '0;
            bitcnt_q <= '0;
            byte_q   <= '0;
            name_q   <= 1'b0;
            length_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= mic;
            sync2_q  <= sync1_q;
            if (ce) prev_q <= sync2_q;
            pulse_q  <= pulse_d;
            timer_q  <= timer_d;
            bitcnt_q <= bitcnt_d;
            byte_q   <= byte_d;
            name_q   <= name_d;
            length_q <= length_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pulse_d  = pulse_q;
        timer_d  = timer_q;
        bitcnt_d = bitcnt_q;
        byte_d   = byte_q;
        name_d   = name_q;
        length_d = length_q;
        ovf_d    = ovf_q;
        wr_en    = 1'b0;
        wr_data  = '0;
        case (state_q)
            IDLE: begin
                if (enable && rise) begin
                    state_d  = BIT;
                    pulse_d  = 4'd1;
                    timer_d  = '0;
                    bitcnt_d = '0;
                    name_d   = SKIP_NAME;
                end
            end
            BIT: begin
                if (!enable) begin
                    state_d  = IDLE;
                    length_d = '0;
                end else if (rise) begin
                    pulse_d = (pulse_q == 4'hF) ? pulse_q : pulse_q + 4'd1;
                    timer_d = '0;
                end else if (ce) begin
                    timer_d = timer_inc;
                    if (timer_inc >= GAP_LIM) begin
                        state_d  = GAP;
                        byte_d   = shifted;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            if (name_q) begin
                                if (shifted[7]) name_d = 1'b0;
                            end else begin
                                wr_en    = 1'b1;
                                wr_data  = shifted;
                                length_d = length_q + 1'b1;
                                if (length_q == LAST_IDX) begin
                                    ovf_d   = 1'b1;
                                    state_d = DONE;
                                end
                            end
                        end
                    end
                end
            end
            GAP: begin
                if (!enable) begin
                    state_d  = IDLE;
                    length_d = '0;
                end else if (rise) begin
                    state_d = BIT;
                    pulse_d = 4'd1;
                    timer_d = '0;
                end else if (ce) begin
                    // timer keeps running from the last edge, so END counts total silence
                    timer_d = timer_inc;
                    if (timer_inc >= END_LIM) begin
                        bitcnt_d = '0;
                        state_d  = (length_q != '0) ? DONE : IDLE;
                    end
                end
            end
            DONE: begin
                if (ack) begin
                    state_d  = IDLE;
                    length_d = '0;
                    ovf_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // buffer has no reset so its contents survive reset and ack
    always_ff @(posedge clk_sys) begin
        if (wr_en) mem[length_q[ADDR_W-1:0]] <= wr_data;
        rd_data <= mem[rd_addr];
    end

    assign active   = (state_q == BIT) || (state_q == GAP);
    assign done     = (state_q == DONE);
    assign overflow = ovf_q;
    assign length   = length_q;

endmodule

// File: tb/tb_tape_saver.sv
// Scoreboard bench for tape_saver with shortened timeouts and a 16-byte buffer.
module tb_tape_saver;

    localparam int AW = 4;

    logic          clk_sys = 1'b0;
    logic          reset, ce, enable, mic, ack;
    logic          active, done, overflow;
    logic [AW:0]   length;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    exp_t st_q[$];
    exp_t rd_q[$];
    exp_t dn_q[$];
    logic st_req, rd_req, rd_req_p;
    logic done_prev;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_sys = ~clk_sys;

    tape_saver #(
        .GAP_TICKS(8),
        .END_TICKS(40),
        .SKIP_NAME(1'b1),
        .ADDR_W(AW)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .ce(ce),
        .enable(enable),
        .mic(mic),
        .ack(ack),
        .active(active),
        .done(done),
        .overflow(overflow),
        .length(length),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    function automatic exp_t mk(string n, logic [7:0] v);
        exp_t e;
        e.name = n;
        e.val  = v;
        return e;
    endfunction

    function automatic logic [7:0] stat(logic a, logic d, logic o, logic [AW:0] len);
        return {a, d, o, len};
    endfunction

    function automatic logic [7:0] ovf_byte(int i);
        return 8'(i * 37 + 5);
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    always @(posedge clk_sys) rd_req_p <= rd_req;

    // monitor: compares whatever the DUT presents against the queued expectations
    initial begin
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (st_req === 1'b1) begin
                if (st_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL status: probe with empty queue");
                end else begin
                    e = st_q.pop_front();
                    check(e.name, {active, done, overflow, length}, e.val);
                end
            end
            if (rd_req_p === 1'b1) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL read: data with empty queue");
                end else begin
                    e = rd_q.pop_front();
                    check(e.name, rd_data, e.val);
                end
            end
            if (done === 1'b1 && done_prev === 1'b0) begin
                if (dn_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=1 length=%0d expected no done", length);
                end else begin
                    e = dn_q.pop_front();
                    check(e.name, {2'b00, overflow, length}, e.val);
                end
            end
            done_prev = done;
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic probe(string name, logic a, logic d, logic o, logic [AW:0] len);
        st_q.push_back(mk(name, stat(a, d, o, len)));
        st_req = 1'b1;
        tick();
        st_req = 1'b0;
    endtask

    task automatic read(string name, logic [AW-1:0] a, logic [7:0] exp);
        rd_q.push_back(mk(name, exp));
        rd_addr = a;
        rd_req  = 1'b1;
        tick();
        rd_req  = 1'b0;
        tick();
    endtask

    task automatic send_bit(int n);
        repeat (n) begin
            mic = 1'b1;
            tick(2);
            mic = 1'b0;
            tick(2);
        end
        tick(12);
    endtask

    task automatic send_byte(logic [7:0] v);
        for (int b = 7; b >= 0; b--) send_bit(v[b] ? 9 : 4);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ce = 1'b1; enable = 1'b0; mic = 1'b0; ack = 1'b0;
        rd_addr = '0; rd_req = 1'b0; st_req = 1'b0;
        tick(3);
        probe("reset_status", 0, 0, 0, 0);
        reset = 1'b0;
        tick(2);

        // basic recording; ack during capture must be ignored
        enable = 1'b1;
        send_byte(8'hA6);
        probe("after_name", 1, 0, 0, 0);
        dn_q.push_back(mk("rec1_done", 8'h03));
        send_byte(8'h00);
        pulse_ack();
        send_byte(8'h7F);
        send_byte(8'hFF);
        tick(60);
        probe("rec1_status", 0, 1, 0, 3);
        read("rec1_b0", 0, 8'h00);
        read("rec1_b1", 1, 8'h7F);
        read("rec1_b2", 2, 8'hFF);
        pulse_ack();
        probe("after_ack", 0, 0, 0, 0);

        // second recording lands at address 0; older byte at 2 survives
        dn_q.push_back(mk("rec2_done", 8'h02));
        send_byte(8'h80);
        send_byte(8'h5A);
        send_byte(8'hC3);
        tick(60);
        probe("rec2_status", 0, 1, 0, 2);
        read("rec2_b0", 0, 8'h5A);
        read("rec2_b1", 1, 8'hC3);
        read("rec2_keep", 2, 8'hFF);
        pulse_ack();

        // multi-byte name and pulse-count thresholds 6/7/20 -> 0x6B
        dn_q.push_back(mk("thr_done", 8'h01));
        send_byte(8'h41);
        send_byte(8'hC1);
        send_bit(6); send_bit(7); send_bit(20); send_bit(1);
        send_bit(15); send_bit(6); send_bit(7); send_bit(9);
        tick(60);
        probe("thr_status", 0, 1, 0, 1);
        read("thr_byte", 0, 8'h6B);
        pulse_ack();

        // name, then 12 bits that finish the name and leave a partial byte
        send_byte(8'h26);
        send_byte(8'hA0);
        send_bit(9); send_bit(4); send_bit(9); send_bit(9);
        probe("partial_mid", 1, 0, 0, 0);
        tick(60);
        probe("partial_idle", 0, 0, 0, 0);

        // enable dropped mid-byte
        send_byte(8'h80);
        send_byte(8'h11);
        send_bit(9); send_bit(4); send_bit(9);
        probe("en_mid", 1, 0, 0, 1);
        enable = 1'b0;
        tick();
        probe("en_abort", 0, 0, 0, 0);
        tick(60);
        enable = 1'b1;

        // reset mid-byte; buffer survives reset
        send_byte(8'h80);
        send_byte(8'h22);
        send_bit(4); send_bit(9);
        probe("rst_mid", 1, 0, 0, 1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        probe("rst_abort", 0, 0, 0, 0);
        tick(60);
        read("rst_keep", 0, 8'h22);

        // overflow: 22 bytes into a 16-byte buffer
        dn_q.push_back(mk("ovf_done", 8'h30));
        send_byte(8'h80);
        for (int i = 0; i < 22; i++) begin
            send_byte(ovf_byte(i));
            if (i == 15) probe("ovf_immediate", 0, 1, 1, 16);
        end
        tick(60);
        probe("ovf_status", 0, 1, 1, 16);
        read("ovf_first", 0, ovf_byte(0));
        read("ovf_last", 15, ovf_byte(15));
        pulse_ack();
        probe("ovf_ack", 0, 0, 0, 0);

        tick(2);
        if (dn_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL missing_done: got %0d pending done events expected 0", dn_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
